// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit.
//   state_t   : access sequencer states (IDLE / RD / WR / RESP)
//   BSEL_*    : encodings of the bsel request input
//   lane_of   : byte-lane index of a byte address
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic BSEL_WORD = 1'b0;
    localparam logic BSEL_BYTE = 1'b1;

    // Little-endian lane: lane 0 is bits 7:0 of the word.
    function automatic logic [1:0] lane_of(input logic [31:0] a);
        return a[1:0];
    endfunction

endpackage

// File: rtl/byte_lane.sv
// Combinational byte-lane extract / merge.
//   word      : 32-bit source word
//   lane      : byte lane (0 = bits 7:0)
//   byte_data : replacement byte for the merge
//   ext_byte  : byte found in the selected lane of word
//   merged    : word with the selected lane replaced by byte_data
module byte_lane (
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [7:0]  byte_data,
    output logic [7:0]  ext_byte,
    output logic [31:0] merged
);

    always_comb begin
        ext_byte = word[7:0];
        case (lane)
            2'd0: ext_byte = word[7:0];
            2'd1: ext_byte = word[15:8];
            2'd2: ext_byte = word[23:16];
            2'd3: ext_byte = word[31:24];
            default: ext_byte = word[7:0];
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[gi*8 +: 8] = (lane == 2'(gi)) ? byte_data : word[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a word-wide memory with combinational read.
// Word loads/stores take one memory cycle; byte stores are done as a
// read-modify-write so the other three lanes are preserved.
//   clk, reset (async, active-low)
//   req/wr/bsel/addr/wdata : request, accepted only while ready=1
//   ready  : idle, can accept a request
//   done   : one-cycle completion pulse; err qualifies it (access rejected)
//   rdata  : last successful load result
//   mem_we/mem_a/mem_wd/mem_rd : memory port (word-aligned byte address)
module mem_access_unit #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic        bsel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);
    import mem_pkg::*;

    state_t      state_reg;
    logic        armed_reg;     // low only until the first edge after reset release
    logic        wr_reg;
    logic        bsel_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] buf_reg;       // RMW merge buffer
    logic [31:0] rdata_reg;
    logic        done_reg;
    logic        err_reg;

    logic        misaligned;
    logic        out_of_range;
    logic [31:0] lane_word;
    logic [7:0]  lane_byte;
    logic [31:0] lane_merged;

    assign misaligned   = (bsel == BSEL_WORD) && (addr[1:0] != 2'b00);
    assign out_of_range = ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));

    // One lane unit serves both paths: in RD it extracts from the live read
    // data (byte load), in WR it merges into the buffered word (byte store).
    assign lane_word = (state_reg == ST_RD) ? mem_rd : buf_reg;

    byte_lane u_byte_lane (
        .word      (lane_word),
        .lane      (lane_of(addr_reg)),
        .byte_data (wdata_reg[7:0]),
        .ext_byte  (lane_byte),
        .merged    (lane_merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            armed_reg <= 1'b0;
            wr_reg    <= 1'b0;
            bsel_reg  <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            buf_reg   <= '0;
            rdata_reg <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            armed_reg <= 1'b1;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req && armed_reg) begin
                        wr_reg    <= wr;
                        bsel_reg  <= bsel;
                        addr_reg  <= addr;
                        wdata_reg <= wdata;
                        if (misaligned || out_of_range) begin
                            state_reg <= ST_RESP;
                            done_reg  <= 1'b1;
                            err_reg   <= 1'b1;
                        end else if (wr && (bsel == BSEL_WORD)) begin
                            state_reg <= ST_WR;
                        end else begin
                            state_reg <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (wr_reg) begin
                        buf_reg   <= mem_rd;
                        state_reg <= ST_WR;
                    end else begin
                        rdata_reg <= (bsel_reg == BSEL_BYTE) ? {24'b0, lane_byte} : mem_rd;
                        state_reg <= ST_RESP;
                        done_reg  <= 1'b1;
                    end
                end
                ST_WR: begin
                    state_reg <= ST_RESP;
                    done_reg  <= 1'b1;
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory-side signals are pure decodes of registered state so they fall
    // to their idle values the instant reset is asserted.
    always_comb begin
        mem_wd = '0;
        if (state_reg == ST_WR) begin
            mem_wd = (bsel_reg == BSEL_BYTE) ? lane_merged : wdata_reg;
        end
    end

    assign mem_we = (state_reg == ST_WR);
    assign mem_a  = (state_reg == ST_IDLE) ? 32'd0 : {addr_reg[31:2], 2'b00};
    assign ready  = (state_reg == ST_IDLE);
    assign done   = done_reg;
    assign err    = err_reg;
    assign rdata  = rdata_reg;

endmodule
